uart_csr_master: RTL

- Debug bridge that turns a byte stream from a UART transceiver into CSR bus transactions: it is the initiator side of the CSR bus that the UART and other peripherals answer as responders.
- Sits between a uart_transceiver instance (rx_data/rx_done in, tx_data/tx_wr/tx_done out) and the CSR bus. This lets a host PC read and write any CSR without the CPU.
- Responses are sent back over the same transceiver.

---
 rtl/uart_csr_pkg.sv | 28 ++
 rtl/uart_csr_master_if.sv | 31 +++
 rtl/uart_csr_txser.sv | 48 ++++
 rtl/uart_csr_master.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_csr_pkg.sv
`default_nettype none
//==============================================================================
// Module  : uart_csr_pkg
// Purpose : Shared widths, command codes and parser states of the UART CSR bridge
// Rev     : 1.0
//==============================================================================
package uart_csr_pkg;

    localparam int CSR_AW = 14;
    localparam int CSR_DW = 32;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR_HI = 4'd1,
        ADDR_LO = 4'd2,
        DATA    = 4'd3,
        CSR_WR  = 4'd4,
        CSR_RD  = 4'd5,
        CSR_CAP = 4'd6,
        TX_SEND = 4'd7,
        TX_WAIT = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_csr_master_if.sv
`default_nettype none
//==============================================================================
// Module  : uart_csr_master_if
// Purpose : Transceiver byte handshake plus CSR bus seen by the debug bridge
// Rev     : 1.0
//==============================================================================
interface uart_csr_master_if;
    import uart_csr_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_done;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_done;
    logic [CSR_AW-1:0] csr_a;
    logic              csr_we;
    logic [CSR_DW-1:0] csr_do;
    logic [CSR_DW-1:0] csr_di;

    modport master (
        input  rx_data, rx_done, tx_done, csr_di,
        output tx_data, tx_wr, csr_a, csr_we, csr_do
    );

    modport slave (
        output rx_data, rx_done, tx_done, csr_di,
        input  tx_data, tx_wr, csr_a, csr_we, csr_do
    );

endinterface
`default_nettype wire

// File: rtl/uart_csr_txser.sv
`default_nettype none
//==============================================================================
// Module  : uart_csr_txser
// Purpose : Response serializer: shift register, byte count, tx_wr/tx_done handshake
// Rev     : 1.0
//==============================================================================
module uart_csr_txser
    import uart_csr_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic [CSR_DW-1:0] load_word,
    input  wire logic [2:0]        load_cnt,
    input  wire logic              send,
    input  wire logic              waiting,
    input  wire logic              tx_done,
    output logic [7:0]             tx_data,
    output logic                   tx_wr,
    output logic                   more
);

    logic [CSR_DW-1:0] r_shift;
    logic [2:0]        r_cnt;
    logic              w_ack;

    // tx_done only counts while the parser is waiting on a byte in flight
    assign w_ack = waiting & tx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= 3'd0;
        end else if (load) begin
            r_shift <= load_word;
            r_cnt   <= load_cnt;
        end else if (w_ack) begin
            r_shift <= {r_shift[CSR_DW-9:0], 8'h00};
            r_cnt   <= r_cnt - 3'd1;
        end
    end

    assign tx_data = r_shift[CSR_DW-1 -: 8];
    assign tx_wr   = send;
    assign more    = (r_cnt > 3'd1);

endmodule
`default_nettype wire

// File: rtl/uart_csr_master.sv
`default_nettype none
//==============================================================================
// Module  : uart_csr_master
// Purpose : UART byte-stream to CSR bus bridge (frame parser, CSR access, response)
// Rev     : 1.0
//==============================================================================
module uart_csr_master
    import uart_csr_pkg::*;
#(
    parameter int         TIMEOUT  = 1000000,
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    uart_csr_master_if.master bus,
    output logic              busy
);

    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_addr_hi;
    logic [CSR_AW-1:0] r_csr_a;
    logic [CSR_DW-1:0] r_wdata;
    logic [1:0]        r_idx;
    logic              r_is_wr;
    logic [c_TW-1:0]   r_tmo;

    logic              w_in_frame;
    logic              w_expired;
    logic              w_load;
    logic [CSR_DW-1:0] w_load_word;
    logic [2:0]        w_load_cnt;
    logic              w_more;
    logic [7:0]        w_tx_data;
    logic              w_tx_wr;

    assign w_in_frame = (r_state == ADDR_HI) || (r_state == ADDR_LO) || (r_state == DATA);
    assign w_expired  = w_in_frame && (r_tmo == c_TMO_MAX);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // rx_done is tested before the timeout so a byte arriving on the expiry cycle is kept
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_word = '0;
        w_load_cnt  = 3'd0;
        case (r_state)
            IDLE: begin
                if (bus.rx_done) begin
                    if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
                        w_next = ADDR_HI;
                    end else begin
                        w_load      = 1'b1;
                        w_load_word = {ERR_BYTE, 24'h000000};
                        w_load_cnt  = 3'd1;
                        w_next      = TX_SEND;
                    end
                end
            end
            ADDR_HI: begin
                if (bus.rx_done) begin
                    w_next = ADDR_LO;
                end else if (w_expired) begin
                    w_next = IDLE;
                end
            end
            ADDR_LO: begin
                if (bus.rx_done) begin
                    w_next = r_is_wr ? DATA : CSR_RD;
                end else if (w_expired) begin
                    w_next = IDLE;
                end
            end
            DATA: begin
                if (bus.rx_done) begin
                    if (r_idx == 2'd3) begin
                        w_next = CSR_WR;
                    end
                end else if (w_expired) begin
                    w_next = IDLE;
                end
            end
            CSR_WR: begin
                w_load      = 1'b1;
                w_load_word = {ACK_BYTE, 24'h000000};
                w_load_cnt  = 3'd1;
                w_next      = TX_SEND;
            end
            CSR_RD: begin
                w_next = CSR_CAP;
            end
            CSR_CAP: begin
                w_load      = 1'b1;
                w_load_word = bus.csr_di;
                w_load_cnt  = 3'd4;
                w_next      = TX_SEND;
            end
            TX_SEND: begin
                w_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.tx_done) begin
                    w_next = w_more ? TX_SEND : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_addr_hi <= 6'd0;
            r_csr_a   <= '0;
            r_wdata   <= '0;
            r_idx     <= 2'd0;
            r_is_wr   <= 1'b0;
            r_tmo     <= '0;
        end else begin
            // Saturating inter-byte gap counter, live only inside a frame
            if (bus.rx_done || !w_in_frame) begin
                r_tmo <= '0;
            end else if (r_tmo != c_TMO_MAX) begin
                r_tmo <= r_tmo + c_TW'(1);
            end

            if (bus.rx_done) begin
                case (r_state)
                    IDLE: begin
                        r_is_wr <= (bus.rx_data == CMD_WR);
                        r_idx   <= 2'd0;
                    end
                    ADDR_HI: begin
                        r_addr_hi <= bus.rx_data[5:0];
                    end
                    ADDR_LO: begin
                        r_csr_a <= {r_addr_hi, bus.rx_data};
                    end
                    DATA: begin
                        r_wdata <= {r_wdata[CSR_DW-9:0], bus.rx_data};
                        r_idx   <= r_idx + 2'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    uart_csr_txser u_txser (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .load      (w_load),
        .load_word (w_load_word),
        .load_cnt  (w_load_cnt),
        .send      (r_state == TX_SEND),
        .waiting   (r_state == TX_WAIT),
        .tx_done   (bus.tx_done),
        .tx_data   (w_tx_data),
        .tx_wr     (w_tx_wr),
        .more      (w_more)
    );

    assign bus.tx_data = w_tx_data;
    assign bus.tx_wr   = w_tx_wr;
    assign bus.csr_a   = r_csr_a;
    assign bus.csr_do  = r_wdata;
    assign bus.csr_we  = (r_state == CSR_WR);
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
